// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter -- iterative AES-128/192/256 encryption core.
// The key size is chosen per block. The key schedule is expanded one word
// per clock, then one cipher round runs per clock. Blocks enter and leave
// through valid/ready handshakes.
// Optional feature macro: AES_ITER_KEY_CACHE_EN. When it is defined, the core
// keeps the last expanded key. A block whose mode and key match the stored
// ones skips key expansion.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready is high only in IDLE
//   in_mode [1:0]       00 AES-128, 01 AES-192, 10 AES-256, 11 illegal
//   in_block [127:0]    plaintext, byte 0 in [127:120]
//   in_key [255:0]      key, left-aligned
//   out_valid/out_ready output handshake; out_valid is held until accepted
//   out_data [127:0]    ciphertext (0 on error)
//   out_err             error result (illegal mode or Nk > MAX_NK)
module aes_cipher_iter #(
  parameter int unsigned MAX_NK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_mode,
  input  logic [127:0] in_block,
  input  logic [255:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_err
);

  localparam int unsigned NWORDS = 4 * (MAX_NK + 7);
  localparam logic [3:0]  MAXNK4 = 4'(MAX_NK);

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

  state_t       st;
  logic [127:0] s;
  logic [31:0]  w [NWORDS];
  logic [5:0]   wi;
  logic [2:0]   wj;
  logic [7:0]   rcon;
  logic [3:0]   rnd;
  logic [3:0]   nk;
  logic [3:0]   nr;

  logic [3:0]   in_nk;
  logic [3:0]   in_nr;
  logic         in_legal;
  logic         hit;
  logic [5:0]   wlast;
  logic [31:0]  kprev;
  logic [31:0]  kback;
  logic [31:0]  ktmp;
  logic [31:0]  kword;
  logic [127:0] rk;
  logic [127:0] round_out;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as x^254 (multiplicative inverse, 0 -> 0) plus the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] p;
    inv = 8'h01;
    p   = x;
    for (int unsigned k = 1; k < 8; k++) begin
      p   = gmul(p, p);
      inv = gmul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st_in,
                                             input logic [127:0] key,
                                             input logic         last);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [127:0] mc;
    logic [7:0]   a0, a1, a2, a3;
    for (int unsigned b = 0; b < 16; b++)
      sb[b] = sbox(st_in[127 - 8 * b -: 8]);
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        sr[4 * c + r] = sb[4 * ((c + r) % 4) + r];
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = sr[4 * c];
      a1 = sr[4 * c + 1];
      a2 = sr[4 * c + 2];
      a3 = sr[4 * c + 3];
      if (last)
        mc[127 - 32 * c -: 32] = {a0, a1, a2, a3};
      else
        mc[127 - 32 * c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return mc ^ key;
  endfunction

  always_comb begin
    in_nk = 4'd4;
    in_nr = 4'd10;
    case (in_mode)
      2'b01:   begin in_nk = 4'd6; in_nr = 4'd12; end
      2'b10:   begin in_nk = 4'd8; in_nr = 4'd14; end
      default: begin in_nk = 4'd4; in_nr = 4'd10; end
    endcase
    in_legal = (in_mode != 2'b11) && (in_nk <= MAXNK4);
  end

  assign in_ready = (st == IDLE) && !rst;

`ifdef AES_ITER_KEY_CACHE_EN
  logic         cvalid;
  logic [1:0]   cmode;
  logic [255:0] ckey;
  logic [255:0] key_masked;

  always_comb begin
    case (in_mode)
      2'b00:   key_masked = {in_key[255:128], 128'd0};
      2'b01:   key_masked = {in_key[255:64], 64'd0};
      default: key_masked = in_key;
    endcase
    hit = cvalid && (cmode == in_mode) && (ckey == key_masked);
  end
`else
  assign hit = 1'b0;
`endif

  // Key expansion: word i from w[i-1] and w[i-Nk]; wj tracks i mod Nk.
  always_comb begin
    wlast = {nr, 2'b00} + 6'd3;
    kprev = w[wi - 6'd1];
    kback = w[wi - {2'b00, nk}];
    ktmp  = kprev;
    if (wj == 3'd0)
      ktmp = subword({kprev[23:0], kprev[31:24]}) ^ {rcon, 24'h000000};
    else if (nk == 4'd8 && wj == 3'd4)
      ktmp = subword(kprev);
    kword = kback ^ ktmp;
    rk = {w[{rnd, 2'd0}], w[{rnd, 2'd1}], w[{rnd, 2'd2}], w[{rnd, 2'd3}]};
    round_out = aes_round(s, rk, rnd == nr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= IDLE;
      s         <= '0;
      wi        <= '0;
      wj        <= '0;
      rcon      <= 8'h01;
      rnd       <= '0;
      nk        <= 4'd4;
      nr        <= 4'd10;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      for (int unsigned k = 0; k < NWORDS; k++) w[k] <= '0;
`ifdef AES_ITER_KEY_CACHE_EN
      cvalid    <= 1'b0;
      cmode     <= '0;
      ckey      <= '0;
`endif
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            if (!in_legal) begin
              // Error result: out_valid rises on the following edge in DONE.
              out_err  <= 1'b1;
              out_data <= '0;
              st       <= DONE;
            end else begin
              out_err <= 1'b0;
              nk      <= in_nk;
              nr      <= in_nr;
              s       <= in_block ^ in_key[255:128];
              if (hit) begin
                rnd <= 4'd1;
                st  <= ROUND;
              end else begin
                for (int unsigned k = 0; k < 8; k++)
                  w[k] <= in_key[255 - 32 * k -: 32];
                wi   <= {2'b00, in_nk};
                wj   <= '0;
                rcon <= 8'h01;
                st   <= KEXP;
`ifdef AES_ITER_KEY_CACHE_EN
                cvalid <= 1'b0;
                cmode  <= in_mode;
                ckey   <= key_masked;
`endif
              end
            end
          end
        end
        KEXP: begin
          w[wi] <= kword;
          if (wj == 3'd0) rcon <= xtime(rcon);
          wj <= ({1'b0, wj} == nk - 4'd1) ? 3'd0 : wj + 3'd1;
          wi <= wi + 6'd1;
          if (wi == wlast) begin
            rnd <= 4'd1;
            st  <= ROUND;
`ifdef AES_ITER_KEY_CACHE_EN
            cvalid <= 1'b1;
`endif
          end
        end
        ROUND: begin
          s <= round_out;
          if (rnd == nr) begin
            out_data  <= round_out;
            out_valid <= 1'b1;
            st        <= DONE;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            st        <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
